// File: rtl/hazard_pipeline_controller_pkg.sv
// Shared encodings for the pipeline sequencer and the datapath muxes it steers.
package hazard_pipeline_controller_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH     = 2'd0,
    ST_RUN       = 2'd1,
    ST_JMPL_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int NUM_OPS = 3;
  localparam int RA_W    = 5;

  // r0 is hardwired zero, so a write to it never produces a usable value.
  function automatic logic reg_hit(logic we, logic [RA_W-1:0] rd, logic [RA_W-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_pipeline_controller_fwd_select.sv
// Per-operand forwarding select: youngest matching producer (EX, then MEM, then WB) wins.
module fwd_select
  import hazard_pipeline_controller_pkg::*;
(
  input  logic            en,
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_we,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_we,
  output logic [1:0]      sel
);

  always_comb begin
    sel = FWD_RF;
    if (en) begin
      if (reg_hit(ex_we, ex_rd, src))        sel = FWD_EX;
      else if (reg_hit(mem_we, mem_rd, src)) sel = FWD_MEM;
      else if (reg_hit(wb_we, wb_rd, src))   sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_pipeline_controller.sv
// 5-stage pipeline sequencer: reset drain, load-use stall, delay-slot annul,
// jmpl redirect, operand forwarding and a saturating bubble counter.
module hazard_pipeline_controller
  import hazard_pipeline_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             R,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_imm,
  input  logic             ID_store,
  input  logic             ID_B_instr,
  input  logic             ID_Call_instr,
  input  logic             ID_jmpl_instr,
  input  logic             ID_29_a,
  input  logic             branch_taken,
  input  logic [4:0]       EX_rd,
  input  logic [4:0]       MEM_rd,
  input  logic [4:0]       WB_rd,
  input  logic             EX_RF_enable,
  input  logic             MEM_RF_enable,
  input  logic             WB_RF_enable,
  input  logic             EX_load_instr,
  output logic             PC_LE,
  output logic             nPC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_clr,
  output logic             S,
  output logic [1:0]       pc_src,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t     state, next_state;
  logic [3:0] flush_cnt;
  logic       load_use;

  logic [NUM_OPS-1:0][RA_W-1:0] op_src;
  logic [NUM_OPS-1:0]           op_en;
  logic [NUM_OPS-1:0][1:0]      op_sel;

  // Operand slots: 0 = rs1, 1 = rs2, 2 = store data (rd). Forced to RF while in reset.
  assign op_src = {ID_rd, ID_rs2, ID_rs1};
  assign op_en  = {ID_store, ~ID_imm, 1'b1} & {NUM_OPS{~R}};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    fwd_select u_fwd (
      .en     (op_en[i]),
      .src    (op_src[i]),
      .ex_rd  (EX_rd),
      .ex_we  (EX_RF_enable),
      .mem_rd (MEM_rd),
      .mem_we (MEM_RF_enable),
      .wb_rd  (WB_rd),
      .wb_we  (WB_RF_enable),
      .sel    (op_sel[i])
    );
  end

  assign fwd_a = op_sel[0];
  assign fwd_b = op_sel[1];
  assign fwd_c = op_sel[2];

  // A load's result is not ready until MEM, so any consumer in ID must wait one cycle.
  assign load_use = EX_load_instr &
                    (reg_hit(EX_RF_enable, EX_rd, ID_rs1) |
                     (~ID_imm   & reg_hit(EX_RF_enable, EX_rd, ID_rs2)) |
                     (ID_store  & reg_hit(EX_RF_enable, EX_rd, ID_rd)));

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      state      <= ST_FLUSH;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      state     <= next_state;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 4'd1 : 4'd0;
      if (S && (state != ST_FLUSH) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    PC_LE      = 1'b0;
    nPC_LE     = 1'b0;
    IF_ID_LE   = 1'b0;
    IF_ID_clr  = 1'b0;
    S          = 1'b1;
    pc_src     = PC_SEQ;
    case (state)
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (load_use) begin
          next_state = ST_RUN;
        end else if (ID_jmpl_instr) begin
          // Let the delay slot enter ID while the target is computed in EX.
          IF_ID_LE   = 1'b1;
          S          = 1'b0;
          next_state = ST_JMPL_WAIT;
        end else begin
          PC_LE    = 1'b1;
          nPC_LE   = 1'b1;
          IF_ID_LE = 1'b1;
          S        = 1'b0;
          if (ID_Call_instr || (ID_B_instr && branch_taken)) pc_src = PC_BR;
          else if (ID_B_instr)                              IF_ID_clr = ID_29_a;
        end
      end
      ST_JMPL_WAIT: begin
        PC_LE      = 1'b1;
        nPC_LE     = 1'b1;
        IF_ID_LE   = 1'b1;
        S          = 1'b0;
        pc_src     = PC_JMP;
        next_state = ST_RUN;
      end
      default: next_state = ST_FLUSH;
    endcase
  end

endmodule

// File: tb/tb_hazard_pipeline_controller.sv
// Directed scenarios plus a randomized run against a rule-level reference model.
module tb_hazard_pipeline_controller;

  localparam int CNT_W = 16;

  logic Clk = 1'b0;
  logic R   = 1'b1;
  logic [4:0] ID_rs1, ID_rs2, ID_rd, EX_rd, MEM_rd, WB_rd;
  logic ID_imm, ID_store, ID_B_instr, ID_Call_instr, ID_jmpl_instr, ID_29_a, branch_taken;
  logic EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr;
  logic PC_LE, nPC_LE, IF_ID_LE, IF_ID_clr, S;
  logic [1:0] pc_src, fwd_a, fwd_b, fwd_c;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int fails  = 0;

  // Model state for the randomized run
  int m_flush_left;
  bit m_jmpl;
  int m_bubbles;

  wire [12:0] obs = {PC_LE, nPC_LE, IF_ID_LE, IF_ID_clr, S, pc_src, fwd_a, fwd_b, fwd_c};

  hazard_pipeline_controller #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .R(R),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd), .ID_imm(ID_imm), .ID_store(ID_store),
    .ID_B_instr(ID_B_instr), .ID_Call_instr(ID_Call_instr), .ID_jmpl_instr(ID_jmpl_instr),
    .ID_29_a(ID_29_a), .branch_taken(branch_taken),
    .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
    .EX_load_instr(EX_load_instr),
    .PC_LE(PC_LE), .nPC_LE(nPC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_clr(IF_ID_clr), .S(S),
    .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .bubble_cnt(bubble_cnt)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // le = {PC_LE, nPC_LE, IF_ID_LE}
  function automatic logic [12:0] pk(logic [2:0] le, logic clr, logic s, logic [1:0] pc,
                                     logic [1:0] fa, logic [1:0] fb, logic [1:0] fc);
    return {le, clr, s, pc, fa, fb, fc};
  endfunction

  task automatic idle();
    ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0; ID_imm = 0; ID_store = 0;
    ID_B_instr = 0; ID_Call_instr = 0; ID_jmpl_instr = 0; ID_29_a = 0; branch_taken = 0;
    EX_rd = 0; MEM_rd = 0; WB_rd = 0;
    EX_RF_enable = 0; MEM_RF_enable = 0; WB_RF_enable = 0; EX_load_instr = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // ---------------- reference model (rule level) ----------------
  function automatic logic [1:0] fwd_ref(logic [4:0] r, logic used);
    logic [4:0] rds [3];
    logic       wes [3];
    rds = '{EX_rd, MEM_rd, WB_rd};
    wes = '{EX_RF_enable, MEM_RF_enable, WB_RF_enable};
    if (!used) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (wes[k] && rds[k] != 0 && rds[k] == r) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic bit load_use_ref();
    bit needs;
    needs = (EX_rd == ID_rs1) || (!ID_imm && EX_rd == ID_rs2) || (ID_store && EX_rd == ID_rd);
    return EX_load_instr && EX_RF_enable && EX_rd != 0 && needs;
  endfunction

  function automatic logic [12:0] expect_ref();
    logic [1:0] fa, fb, fc;
    fa = fwd_ref(ID_rs1, 1'b1);
    fb = fwd_ref(ID_rs2, !ID_imm);
    fc = fwd_ref(ID_rd, ID_store);
    if (m_flush_left > 0)  return pk(3'b000, 0, 1, 2'd0, fa, fb, fc);
    if (m_jmpl)            return pk(3'b111, 0, 0, 2'd2, fa, fb, fc);
    if (load_use_ref())    return pk(3'b000, 0, 1, 2'd0, fa, fb, fc);
    if (ID_jmpl_instr)     return pk(3'b001, 0, 0, 2'd0, fa, fb, fc);
    if (ID_Call_instr || (ID_B_instr && branch_taken))
                           return pk(3'b111, 0, 0, 2'd1, fa, fb, fc);
    if (ID_B_instr)        return pk(3'b111, ID_29_a, 0, 2'd0, fa, fb, fc);
    return pk(3'b111, 0, 0, 2'd0, fa, fb, fc);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n = 0;
    int le_bad = 0;
    #1;
    for (int i = 0; i < 8 && S === 1'b1; i++) begin
      if ({PC_LE, nPC_LE, IF_ID_LE} !== 3'b000) le_bad++;
      n++;
      tick();
    end
    checks++;
    if (n != 3 || le_bad != 0) begin
      fails++; $display("FAIL reset_drain: flush cycles=%0d (le_bad=%0d), expected 3 (0)", n, le_bad);
    end
    checks++;
    if (obs !== pk(3'b111, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL reset_run_entry: got %h expected %h", obs, pk(3'b111, 0, 0, 0, 0, 0, 0));
    end
    checks++;
    if (bubble_cnt !== 0) begin
      fails++; $display("FAIL reset_bubble: got %0d expected 0", bubble_cnt);
    end
  endtask

  task automatic test_load_use();
    idle(); EX_load_instr = 1; EX_RF_enable = 1; EX_rd = 5; ID_rs1 = 5; ID_imm = 1;
    #1; checks++;
    if (obs !== pk(3'b000, 0, 1, 0, 1, 0, 0)) begin
      fails++; $display("FAIL lu_stall: got %h expected %h", obs, pk(3'b000, 0, 1, 0, 1, 0, 0));
    end
    tick();
    EX_load_instr = 0; EX_RF_enable = 0; EX_rd = 0; MEM_rd = 5; MEM_RF_enable = 1;
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 0, 2, 0, 0)) begin
      fails++; $display("FAIL lu_resume: got %h expected %h", obs, pk(3'b111, 0, 0, 0, 2, 0, 0));
    end
    checks++;
    if (bubble_cnt !== 1) begin
      fails++; $display("FAIL lu_bubble: got %0d expected 1", bubble_cnt);
    end
    tick();
    idle(); EX_load_instr = 1; EX_RF_enable = 1; EX_rd = 0; ID_rs1 = 0;
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL lu_rd0: got %h expected %h", obs, pk(3'b111, 0, 0, 0, 0, 0, 0));
    end
    tick();
    EX_rd = 7; ID_rs1 = 1; ID_rs2 = 7; ID_imm = 0;
    #1; checks++;
    if (obs !== pk(3'b000, 0, 1, 0, 0, 1, 0)) begin
      fails++; $display("FAIL lu_rs2: got %h expected %h", obs, pk(3'b000, 0, 1, 0, 0, 1, 0));
    end
    tick();
    ID_imm = 1;
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL lu_imm: got %h expected %h", obs, pk(3'b111, 0, 0, 0, 0, 0, 0));
    end
    tick();
    ID_store = 1; ID_rd = 7;
    #1; checks++;
    if (obs !== pk(3'b000, 0, 1, 0, 0, 0, 1)) begin
      fails++; $display("FAIL lu_store: got %h expected %h", obs, pk(3'b000, 0, 1, 0, 0, 0, 1));
    end
    tick();
    idle();
    #1; checks++;
    if (bubble_cnt !== 3) begin
      fails++; $display("FAIL lu_bubble3: got %0d expected 3", bubble_cnt);
    end
    tick();
  endtask

  task automatic test_fwd_priority();
    idle(); EX_rd = 3; MEM_rd = 3; WB_rd = 3;
    EX_RF_enable = 1; MEM_RF_enable = 1; WB_RF_enable = 1; ID_rs1 = 4; ID_rs2 = 3;
    #1; checks++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b00_01_00) begin
      fails++; $display("FAIL fwd_ex: got %b expected 000100", {fwd_a, fwd_b, fwd_c});
    end
    tick(); EX_RF_enable = 0;
    #1; checks++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b00_10_00) begin
      fails++; $display("FAIL fwd_mem: got %b expected 001000", {fwd_a, fwd_b, fwd_c});
    end
    tick(); MEM_RF_enable = 0;
    #1; checks++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b00_11_00) begin
      fails++; $display("FAIL fwd_wb: got %b expected 001100", {fwd_a, fwd_b, fwd_c});
    end
    tick(); ID_imm = 1;
    #1; checks++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b00_00_00) begin
      fails++; $display("FAIL fwd_imm: got %b expected 000000", {fwd_a, fwd_b, fwd_c});
    end
    tick(); ID_store = 1; ID_rd = 3; ID_rs1 = 3;
    #1; checks++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b11_00_11) begin
      fails++; $display("FAIL fwd_store: got %b expected 110011", {fwd_a, fwd_b, fwd_c});
    end
    tick(); ID_store = 0;
    #1; checks++;
    if (fwd_c !== 2'd0) begin
      fails++; $display("FAIL fwd_nostore: got %0d expected 0", fwd_c);
    end
    tick(); idle(); EX_RF_enable = 1; MEM_RF_enable = 1; WB_RF_enable = 1; ID_store = 1;
    #1; checks++;
    if ({fwd_a, fwd_b, fwd_c} !== 6'b00_00_00) begin
      fails++; $display("FAIL fwd_r0: got %b expected 000000", {fwd_a, fwd_b, fwd_c});
    end
    tick(); idle();
  endtask

  task automatic test_branch();
    idle(); ID_B_instr = 1; ID_29_a = 1;
    #1; checks++;
    if (obs !== pk(3'b111, 1, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL br_nt_annul: got %h expected %h", obs, pk(3'b111, 1, 0, 0, 0, 0, 0));
    end
    tick(); branch_taken = 1;
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 1, 0, 0, 0)) begin
      fails++; $display("FAIL br_taken: got %h expected %h", obs, pk(3'b111, 0, 0, 1, 0, 0, 0));
    end
    tick(); idle(); ID_Call_instr = 1;
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 1, 0, 0, 0)) begin
      fails++; $display("FAIL call: got %h expected %h", obs, pk(3'b111, 0, 0, 1, 0, 0, 0));
    end
    tick(); idle(); ID_B_instr = 1;
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL br_nt_noannul: got %h expected %h", obs, pk(3'b111, 0, 0, 0, 0, 0, 0));
    end
    tick(); idle();
  endtask

  task automatic test_jmpl();
    idle(); ID_jmpl_instr = 1;
    #1; checks++;
    if (obs !== pk(3'b001, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL jmpl_id: got %h expected %h", obs, pk(3'b001, 0, 0, 0, 0, 0, 0));
    end
    tick();
    ID_jmpl_instr = 0; EX_load_instr = 1; EX_RF_enable = 1; EX_rd = 6; ID_rs1 = 6; ID_imm = 1;
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 2, 1, 0, 0)) begin
      fails++; $display("FAIL jmpl_wait: got %h expected %h", obs, pk(3'b111, 0, 0, 2, 1, 0, 0));
    end
    tick(); idle();
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL jmpl_back_run: got %h expected %h", obs, pk(3'b111, 0, 0, 0, 0, 0, 0));
    end
    tick();
    ID_jmpl_instr = 1; EX_load_instr = 1; EX_RF_enable = 1; EX_rd = 6; ID_rs1 = 6; ID_imm = 1;
    #1; checks++;
    if (obs !== pk(3'b000, 0, 1, 0, 1, 0, 0)) begin
      fails++; $display("FAIL jmpl_lu_stall: got %h expected %h", obs, pk(3'b000, 0, 1, 0, 1, 0, 0));
    end
    tick(); EX_load_instr = 0; EX_RF_enable = 0; EX_rd = 0;
    #1; checks++;
    if (obs !== pk(3'b001, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL jmpl_after_stall: got %h expected %h", obs, pk(3'b001, 0, 0, 0, 0, 0, 0));
    end
    tick(); ID_jmpl_instr = 0;
    #1; checks++;
    if (obs !== pk(3'b111, 0, 0, 2, 0, 0, 0)) begin
      fails++; $display("FAIL jmpl_after_stall_wait: got %h expected %h", obs, pk(3'b111, 0, 0, 2, 0, 0, 0));
    end
    tick(); idle();
  endtask

  task automatic test_mid_reset();
    idle(); ID_jmpl_instr = 1;
    tick();
    ID_jmpl_instr = 0; WB_rd = 2; WB_RF_enable = 1; ID_rs1 = 2;
    R = 1;
    #1; checks++;
    if (obs !== pk(3'b000, 0, 1, 0, 0, 0, 0)) begin
      fails++; $display("FAIL mr_outputs: got %h expected %h", obs, pk(3'b000, 0, 1, 0, 0, 0, 0));
    end
    checks++;
    if (bubble_cnt !== 0) begin
      fails++; $display("FAIL mr_bubble: got %0d expected 0", bubble_cnt);
    end
    R = 0;
    #1; checks++;
    if (obs !== pk(3'b000, 0, 1, 0, 3, 0, 0)) begin
      fails++; $display("FAIL mr_release: got %h expected %h", obs, pk(3'b000, 0, 1, 0, 3, 0, 0));
    end
    idle();
    tick(); tick(); tick();
    checks++;
    if (obs !== pk(3'b111, 0, 0, 0, 0, 0, 0)) begin
      fails++; $display("FAIL mr_run: got %h expected %h", obs, pk(3'b111, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_saturate();
    idle(); EX_load_instr = 1; EX_RF_enable = 1; EX_rd = 9; ID_rs1 = 9;
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (bubble_cnt !== 16'hFFFE) begin
      fails++; $display("FAIL sat_edge: got %h expected fffe", bubble_cnt);
    end
    tick();
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL sat_reach: got %h expected ffff", bubble_cnt);
    end
    for (int i = 0; i < 70000 - 65535; i++) tick();
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL sat_hold: got %h expected ffff", bubble_cnt);
    end
    idle();
  endtask

  task automatic test_random();
    logic [12:0] exp_o;
    bit lu;
    R = 1; idle();
    #1; R = 0;
    m_flush_left = 3; m_jmpl = 0; m_bubbles = 0;
    for (int i = 0; i < 400; i++) begin
      ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
      ID_rd  = 5'($urandom_range(0, 3));
      EX_rd  = 5'($urandom_range(0, 3)); MEM_rd = 5'($urandom_range(0, 3));
      WB_rd  = 5'($urandom_range(0, 3));
      ID_imm = 1'($urandom_range(0, 1)); ID_store = 1'($urandom_range(0, 1));
      EX_RF_enable  = 1'($urandom_range(0, 1)); MEM_RF_enable = 1'($urandom_range(0, 1));
      WB_RF_enable  = 1'($urandom_range(0, 1));
      EX_load_instr = ($urandom_range(0, 2) == 0);
      ID_jmpl_instr = ($urandom_range(0, 5) == 0);
      ID_B_instr    = ($urandom_range(0, 2) == 0);
      ID_Call_instr = ($urandom_range(0, 5) == 0);
      ID_29_a       = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      #1;
      exp_o = expect_ref();
      checks++;
      if (obs !== exp_o) begin
        fails++; $display("FAIL rand_out[%0d]: got %h expected %h", i, obs, exp_o);
      end
      checks++;
      if (bubble_cnt !== CNT_W'(m_bubbles)) begin
        fails++; $display("FAIL rand_bubble[%0d]: got %0d expected %0d", i, bubble_cnt, m_bubbles);
      end
      lu = load_use_ref();
      if (m_flush_left > 0)   m_flush_left--;
      else if (m_jmpl)        m_jmpl = 0;
      else if (lu)            m_bubbles = (m_bubbles < 65535) ? m_bubbles + 1 : 65535;
      else if (ID_jmpl_instr) m_jmpl = 1;
      tick();
    end
    idle();
  endtask

  initial begin
    R = 1;
    idle();
    #1 R = 0;
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_branch();
    test_jmpl();
    test_mid_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
